// File: rtl/move_sequencer_if.sv
// Request/command bundle between a motion requester and move_sequencer.
// The requester owns the request fields and abort; the sequencer owns the rest.
interface move_sequencer_if #(
  parameter int DUR_W = 12
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_dir;
  logic [DUR_W-1:0] req_ms;
  logic             abort;
  logic [2:0]       movementCommand;
  logic             busy;
  logic             done;
  logic             aborted;

  modport master (
    output req_valid, req_dir, req_ms, abort,
    input  req_ready, movementCommand, busy, done, aborted
  );

  modport slave (
    input  req_valid, req_dir, req_ms, abort,
    output req_ready, movementCommand, busy, done, aborted
  );
endinterface

// File: rtl/move_sequencer.sv
// Timed motion sequencer: holds one direction for req_ms milliseconds, then
// forces a STOP cool-down of DEAD_MS milliseconds before the next move.
module move_sequencer #(
  parameter int TICKS_PER_MS = 100000,
  parameter int DUR_W        = 12,
  parameter int DEAD_MS      = 20
) (
  input logic             CLK100MHZ,
  input logic             reset,
  move_sequencer_if.slave bus
);
  localparam int              TW        = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam int              CW        = $clog2(DEAD_MS + 1);
  localparam logic [TW-1:0]   TICK_LAST = TW'(TICKS_PER_MS - 1);
  localparam logic [CW-1:0]   DEAD_LOAD = CW'(DEAD_MS);
  localparam logic [2:0]      CMD_STOP  = 3'b010;

  typedef enum logic [1:0] {IDLE, RUN, COOL} state_t;

  state_t           state;
  logic [TW-1:0]    tick_cnt;
  logic [DUR_W-1:0] ms_left;
  logic [CW-1:0]    cool_left;
  logic             ms_tick;
  logic             accept;

  // Codes the decoder does not treat as motion are executed as a timed STOP.
  function automatic logic [2:0] map_dir(input logic [2:0] d);
    case (d)
      3'b000, 3'b001, 3'b100, 3'b101: return d;
      default:                        return CMD_STOP;
    endcase
  endfunction

  assign bus.req_ready = (state == IDLE) && !bus.abort;
  assign accept        = bus.req_valid && bus.req_ready;
  assign ms_tick       = (tick_cnt == TICK_LAST);

  // NOTE: every register here uses <= so all state updates see the pre-edge
  // values; blocking assignments would make the order of statements matter.
  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state               <= IDLE;
      tick_cnt            <= '0;
      ms_left             <= '0;
      cool_left           <= '0;
      bus.movementCommand <= CMD_STOP;
      bus.busy            <= 1'b0;
      bus.done            <= 1'b0;
      bus.aborted         <= 1'b0;
    end else begin
      bus.done    <= 1'b0;
      bus.aborted <= 1'b0;
      case (state)
        IDLE: begin
          tick_cnt <= '0;
          if (accept) begin
            if (bus.req_ms == '0) begin
              bus.done <= 1'b1;
            end else begin
              state               <= RUN;
              ms_left             <= bus.req_ms;
              bus.movementCommand <= map_dir(bus.req_dir);
              bus.busy            <= 1'b1;
            end
          end
        end

        RUN: begin
          tick_cnt <= ms_tick ? '0 : tick_cnt + 1'b1;
          if (bus.abort) begin
            // Abort beats a coincident final tick: no done, full cool-down.
            state               <= COOL;
            tick_cnt            <= '0;
            cool_left           <= DEAD_LOAD;
            bus.movementCommand <= CMD_STOP;
            bus.aborted         <= 1'b1;
          end else if (ms_tick) begin
            if (ms_left == DUR_W'(1)) begin
              state               <= COOL;
              cool_left           <= DEAD_LOAD;
              bus.movementCommand <= CMD_STOP;
              bus.done            <= 1'b1;
            end else begin
              ms_left <= ms_left - 1'b1;
            end
          end
        end

        COOL: begin
          if (bus.abort) begin
            tick_cnt  <= '0;
            cool_left <= DEAD_LOAD;
          end else begin
            tick_cnt <= ms_tick ? '0 : tick_cnt + 1'b1;
            if (ms_tick) begin
              if (cool_left == CW'(1)) begin
                state     <= IDLE;
                cool_left <= '0;
                bus.busy  <= 1'b0;
              end else begin
                cool_left <= cool_left - 1'b1;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule
